ptr_ring_router_v2: RTL

- Parametrised next-generation PtRing router stop. One instance sits between the upstream and downstream ring links and one local node.
- Ring and local paths use valid/ready handshakes. The ring, injection and ejection FIFO depths are configurable.
- Each hop costs one cycle through a registered output stage when uncontended.
- Injection arbitration is ring-priority with a starvation guard. Malformed local destinations are dropped and flagged.

---
 rtl/ptr_ring_pkg.sv | 23 ++
 rtl/ptr_ring_router_v2_fifo.sv | 52 +++++
 rtl/ptr_ring_router_v2.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ptr_ring_pkg.sv
// Shared types for the PtRing router stop: destination width helper,
// default flit layout and the per-slot arbitration outcome.
package ptr_ring_pkg;

    function automatic int destWidth(input int nodeNum);
        return (nodeNum > 2) ? $clog2(nodeNum) : 1;
    endfunction

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int FLIT_NODE_NUM   = 8;

    typedef struct packed {
        logic [destWidth(FLIT_NODE_NUM)-1:0] dest;
        logic [FLIT_DATA_WIDTH-1:0]          dat;
    } flit_t;

    typedef enum logic [1:0] {
        ARB_RING,
        ARB_INJ,
        ARB_NONE
    } arb_e;

endpackage

// File: rtl/ptr_ring_router_v2_fifo.sv
// Small synchronous FIFO with registered storage; push while full and
// pop while empty are ignored.
module ptr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             notEmpty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign notEmpty = (count != '0);
    assign doPush   = push & ~full;
    assign doPop    = pop & notEmpty;
    assign head     = mem[rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/ptr_ring_router_v2.sv
// PtRing router stop: forwards, ejects and injects flits on a unidirectional
// ring through one registered output stage; ring traffic beats injection.
module ptr_ring_router_v2
    import ptr_ring_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  NODE_NUM     = 8,
    parameter int  RBUF_DEPTH   = 4,
    parameter int  LBUF_DEPTH   = 2,
    parameter int  STARVE_LIMIT = 4,
    localparam int DEST_W       = destWidth(NODE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ring_in_vld,
    input  logic [DEST_W-1:0]     ring_in_dest,
    input  logic [DATA_WIDTH-1:0] ring_in_dat,
    output logic                  ring_in_rdy,
    output logic                  ring_out_vld,
    output logic [DEST_W-1:0]     ring_out_dest,
    output logic [DATA_WIDTH-1:0] ring_out_dat,
    input  logic                  ring_out_rdy,
    input  logic                  l2r_vld,
    input  logic [DEST_W-1:0]     l2r_dest,
    input  logic [DATA_WIDTH-1:0] l2r_dat,
    output logic                  l2r_rdy,
    output logic                  r2l_vld,
    output logic [DATA_WIDTH-1:0] r2l_dat,
    input  logic                  r2l_rdy,
    output logic                  err_bad_dest
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [DEST_W-1:0]     dest;
        logic [DATA_WIDTH-1:0] dat;
    } routerFlit_t;

    localparam int FW = $bits(routerFlit_t);

    routerFlit_t fwdFlit, fwdCand, rbHead, injHead, injFlit, outFlit;
    logic        rbFull, rbNotEmpty, rbPush, rbPop;
    logic        injFull, injNotEmpty, injPush, injPop;
    logic        ejFull, ejNotEmpty, ejPush;
    logic        inEject, inFwd, ringAcc, fwdAcc;
    logic        l2rAcc, badDest;
    logic        loadSlot, fwdPending, outVld, errBadDest;
    logic [SW-1:0] starveCnt;
    arb_e        arbSel;

    // Readiness looks only at the arriving destination and local FIFO state.
    assign inEject     = (ring_in_dest == DEST_W'(1));
    assign inFwd       = (ring_in_dest > DEST_W'(1));
    assign ring_in_rdy = inEject ? ~ejFull : (inFwd ? ~rbFull : 1'b1);
    assign ringAcc     = ring_in_vld & ring_in_rdy;
    assign fwdAcc      = ringAcc & inFwd;
    assign ejPush      = ringAcc & inEject;

    assign fwdFlit.dest = ring_in_dest - DEST_W'(1);
    assign fwdFlit.dat  = ring_in_dat;

    assign injFlit.dest = l2r_dest;
    assign injFlit.dat  = l2r_dat;
    assign badDest      = (l2r_dest == '0) || (32'(l2r_dest) >= NODE_NUM);
    assign l2r_rdy      = ~injFull;
    assign l2rAcc       = l2r_vld & l2r_rdy;
    assign injPush      = l2rAcc & ~badDest;

    assign loadSlot   = ~outVld | ring_out_rdy;
    assign fwdPending = rbNotEmpty | fwdAcc;
    assign fwdCand    = rbNotEmpty ? rbHead : fwdFlit;

    always_comb begin
        arbSel = ARB_NONE;
        if (loadSlot) begin
            if (injNotEmpty && (starveCnt == SW'(STARVE_LIMIT) || !fwdPending))
                arbSel = ARB_INJ;
            else if (fwdPending)
                arbSel = ARB_RING;
        end
    end

    // The arriving flit bypasses the ring FIFO only when it is empty and ring wins.
    assign rbPop  = (arbSel == ARB_RING) & rbNotEmpty;
    assign rbPush = fwdAcc & ~((arbSel == ARB_RING) & ~rbNotEmpty);
    assign injPop = (arbSel == ARB_INJ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outVld  <= 1'b0;
            outFlit <= '0;
        end else if (loadSlot) begin
            case (arbSel)
                ARB_RING: begin
                    outVld  <= 1'b1;
                    outFlit <= fwdCand;
                end
                ARB_INJ: begin
                    outVld  <= 1'b1;
                    outFlit <= injHead;
                end
                default: outVld <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starveCnt <= '0;
        else if (!injNotEmpty || arbSel == ARB_INJ)
            starveCnt <= '0;
        else if (arbSel == ARB_RING && starveCnt != SW'(STARVE_LIMIT))
            starveCnt <= starveCnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) errBadDest <= 1'b0;
        else      errBadDest <= l2rAcc & badDest;
    end

    assign ring_out_vld  = outVld;
    assign ring_out_dest = outFlit.dest;
    assign ring_out_dat  = outFlit.dat;
    assign r2l_vld       = ejNotEmpty;
    assign err_bad_dest  = errBadDest;

    ptr_sync_fifo #(.WIDTH(FW), .DEPTH(RBUF_DEPTH)) ringFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rbPush),
        .pushData (fwdFlit),
        .pop      (rbPop),
        .full     (rbFull),
        .notEmpty (rbNotEmpty),
        .head     (rbHead)
    );

    ptr_sync_fifo #(.WIDTH(FW), .DEPTH(LBUF_DEPTH)) injFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (injPush),
        .pushData (injFlit),
        .pop      (injPop),
        .full     (injFull),
        .notEmpty (injNotEmpty),
        .head     (injHead)
    );

    ptr_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(LBUF_DEPTH)) ejFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ejPush),
        .pushData (ring_in_dat),
        .pop      (r2l_rdy),
        .full     (ejFull),
        .notEmpty (ejNotEmpty),
        .head     (r2l_dat)
    );

endmodule
